sprite_plot_scheduler: RTL and testbench



---
 rtl/sprite_pkg.sv | 21 ++
 rtl/lowest_set_onehot.sv | 29 ++
 rtl/sprite_plot_scheduler.sv | 173 +++++++++++++++++
 tb/tb_sprite_plot_scheduler.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite plot path.
// - state_e     : scheduler FSM states (IDLE / SCAN / BURST)
// - X_W/Y_W/C_W : default pixel x, y and colour widths for a 320x240 frame
// - PLAYER/ALIENS/BULLET : requester indices, which also set the service order
package sprite_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    BURST = 2'd2
  } state_e;

  localparam int X_W = 9;
  localparam int Y_W = 8;
  localparam int C_W = 3;

  localparam int PLAYER = 0;
  localparam int ALIENS = 1;
  localparam int BULLET = 2;

endpackage

// File: rtl/lowest_set_onehot.sv
// Combinational lowest-set-bit finder.
// Ports:
//   vec    : candidate mask
//   onehot : one-hot of the lowest set bit of vec, zero when vec is zero
//   any    : high when any bit of vec is set
module lowest_set_onehot #(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] vec,
  output logic [NUM_REQ-1:0] onehot,
  output logic               any
);

  logic found;

  always_comb begin
    onehot = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (vec[i] && !found) begin
        onehot[i] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  assign any = |vec;

endmodule

// File: rtl/sprite_plot_scheduler.sv
// Shares the single VGA plot port between the sprite engines.
// On frame_tick the current req mask is snapshotted; engines are then granted
// one at a time in ascending index order, each streaming pixels until it raises
// done or the per-burst watchdog forces a release.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   frame_tick        : frame-start pulse
//   req               : per-engine draw request (level, sampled at frame_tick)
//   pix_valid/x/y/colour/done : per-engine pixel stream, packed per engine
//   grant             : one-hot grant (or zero)
//   x, y, colour, plot: registered plot port, 1 cycle after the granted input
//   busy              : frame service in progress
//   frame_done        : pulse when all snapshotted engines were serviced
//   overrun           : pulse when frame_tick arrives while busy (tick dropped)
//   timeout           : pulse when the watchdog forced a release
module sprite_plot_scheduler #(
  parameter int NUM_REQ   = sprite_pkg::BULLET + 1,
  parameter int X_W       = sprite_pkg::X_W,
  parameter int Y_W       = sprite_pkg::Y_W,
  parameter int C_W       = sprite_pkg::C_W,
  parameter int MAX_BURST = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_tick,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     pix_valid,
  input  logic [NUM_REQ*X_W-1:0] pix_x,
  input  logic [NUM_REQ*Y_W-1:0] pix_y,
  input  logic [NUM_REQ*C_W-1:0] pix_colour,
  input  logic [NUM_REQ-1:0]     done,
  output logic [NUM_REQ-1:0]     grant,
  output logic [X_W-1:0]         x,
  output logic [Y_W-1:0]         y,
  output logic [C_W-1:0]         colour,
  output logic                   plot,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   overrun,
  output logic                   timeout
);

  import sprite_pkg::*;

  localparam int              WD_W    = $clog2(MAX_BURST);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MAX_BURST - 1);

  state_e             state, state_n;
  logic [NUM_REQ-1:0] pending, pending_n, grant_n;
  logic [WD_W-1:0]    wdog, wdog_n;
  logic [X_W-1:0]     x_n;
  logic [Y_W-1:0]     y_n;
  logic [C_W-1:0]     colour_n;
  logic               plot_n, busy_n, frame_done_n, overrun_n, timeout_n;

  logic [NUM_REQ-1:0] pick;
  logic               pick_any;

  lowest_set_onehot #(.NUM_REQ(NUM_REQ)) u_pick (
    .vec    (pending),
    .onehot (pick),
    .any    (pick_any)
  );

  // Grant is one-hot, so OR-ing the masked engine fields selects the owner.
  logic [X_W-1:0] sel_x;
  logic [Y_W-1:0] sel_y;
  logic [C_W-1:0] sel_c;
  logic           sel_valid, sel_done;

  always_comb begin
    sel_x = '0;
    sel_y = '0;
    sel_c = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_x = sel_x | pix_x[i*X_W +: X_W];
        sel_y = sel_y | pix_y[i*Y_W +: Y_W];
        sel_c = sel_c | pix_colour[i*C_W +: C_W];
      end
    end
  end

  assign sel_valid = |(pix_valid & grant);
  assign sel_done  = |(done & grant);

  always_comb begin
    state_n      = state;
    pending_n    = pending;
    grant_n      = grant;
    wdog_n       = wdog;
    x_n          = x;
    y_n          = y;
    colour_n     = colour;
    plot_n       = 1'b0;
    busy_n       = busy;
    frame_done_n = 1'b0;
    timeout_n    = 1'b0;
    // A tick outside IDLE is reported and otherwise ignored.
    overrun_n    = frame_tick && (state != IDLE);

    case (state)
      IDLE: begin
        if (frame_tick) begin
          pending_n = req;
          busy_n    = 1'b1;
          state_n   = SCAN;
        end
      end
      SCAN: begin
        if (!pick_any) begin
          frame_done_n = 1'b1;
          busy_n       = 1'b0;
          state_n      = IDLE;
        end else begin
          grant_n   = pick;
          pending_n = pending & ~pick;
          wdog_n    = '0;
          state_n   = BURST;
        end
      end
      BURST: begin
        x_n      = sel_x;
        y_n      = sel_y;
        colour_n = sel_c;
        plot_n   = sel_valid;
        if (wdog != WD_LAST) wdog_n = wdog + WD_W'(1);
        // done wins over the watchdog on the same cycle; the pixel on the
        // done cycle is still forwarded above.
        if (sel_done) begin
          grant_n = '0;
          state_n = SCAN;
        end else if (wdog == WD_LAST) begin
          grant_n   = '0;
          timeout_n = 1'b1;
          state_n   = SCAN;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pending    <= '0;
      grant      <= '0;
      wdog       <= '0;
      x          <= '0;
      y          <= '0;
      colour     <= '0;
      plot       <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_n;
      pending    <= pending_n;
      grant      <= grant_n;
      wdog       <= wdog_n;
      x          <= x_n;
      y          <= y_n;
      colour     <= colour_n;
      plot       <= plot_n;
      busy       <= busy_n;
      frame_done <= frame_done_n;
      overrun    <= overrun_n;
      timeout    <= timeout_n;
    end
  end

endmodule

// File: tb/tb_sprite_plot_scheduler.sv
// Directed bench for sprite_plot_scheduler with a frame-level reference model
// checked every cycle, plus literal expectations per scenario.
module tb_sprite_plot_scheduler;
  import sprite_pkg::*;

  localparam int N  = 3;
  localparam int XW = 9;
  localparam int YW = 8;
  localparam int CW = 3;
  localparam int MB = 8;

  logic clk = 1'b0, reset = 1'b1, frame_tick = 1'b0;
  logic [N-1:0]    req = '0, pix_valid = '0, done = '0;
  logic [N*XW-1:0] pix_x = '0;
  logic [N*YW-1:0] pix_y = '0;
  logic [N*CW-1:0] pix_colour = '0;
  logic [N-1:0]    grant;
  logic [XW-1:0]   x;
  logic [YW-1:0]   y;
  logic [CW-1:0]   colour;
  logic            plot, busy, frame_done, overrun, timeout;

  always #5 clk = ~clk;

  sprite_plot_scheduler #(
    .NUM_REQ(N), .X_W(XW), .Y_W(YW), .C_W(CW), .MAX_BURST(MB)
  ) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .req(req),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .pix_colour(pix_colour), .done(done), .grant(grant), .x(x), .y(y),
    .colour(colour), .plot(plot), .busy(busy), .frame_done(frame_done),
    .overrun(overrun), .timeout(timeout)
  );

  int checks = 0, errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Frame view: a snapshot set of engines, served lowest-first; each one owns
  // the port until its done or until it has held it MB cycles.
  bit          m_busy = 0, m_scan = 0;
  int          m_cur = -1, m_held = 0;
  logic [N-1:0] m_pend = '0;
  logic [N-1:0] e_grant;
  logic [XW-1:0] e_x;
  logic [YW-1:0] e_y;
  logic [CW-1:0] e_c;
  bit          e_plot, e_fd, e_ov, e_to;
  int          plot_cnt = 0, fd_cnt = 0, ov_cnt = 0, to_cnt = 0;
  int          g_cnt [N];

  always @(posedge clk) begin
    e_plot = 0; e_fd = 0; e_to = 0;
    e_ov   = frame_tick && m_busy;
    if (reset) begin
      m_busy = 0; m_scan = 0; m_cur = -1; m_pend = '0; e_ov = 0;
    end else if (!m_busy) begin
      if (frame_tick) begin m_pend = req; m_busy = 1; m_scan = 1; end
    end else if (m_scan) begin
      m_scan = 0;
      if (m_pend == '0) begin
        e_fd = 1; m_busy = 0;
      end else begin
        for (int i = N - 1; i >= 0; i--) if (m_pend[i]) m_cur = i;
        m_pend[m_cur] = 1'b0;
        m_held = 0;
      end
    end else if (m_cur >= 0) begin
      e_plot = pix_valid[m_cur];
      e_x = pix_x[m_cur*XW +: XW];
      e_y = pix_y[m_cur*YW +: YW];
      e_c = pix_colour[m_cur*CW +: CW];
      m_held++;
      if (done[m_cur]) begin
        m_cur = -1; m_scan = 1;
      end else if (m_held == MB) begin
        m_cur = -1; m_scan = 1; e_to = 1;
      end
    end
    #2;
    e_grant = '0;
    if (m_cur >= 0) e_grant[m_cur] = 1'b1;
    chk("grant", grant, e_grant);
    chk("plot", plot, e_plot);
    chk("busy", busy, m_busy);
    chk("frame_done", frame_done, e_fd);
    chk("overrun", overrun, e_ov);
    chk("timeout", timeout, e_to);
    if (e_plot) begin
      chk("x", x, e_x);
      chk("y", y, e_y);
      chk("colour", colour, e_c);
    end
    if (plot === 1'b1) plot_cnt++;
    if (frame_done === 1'b1) fd_cnt++;
    if (overrun === 1'b1) ov_cnt++;
    if (timeout === 1'b1) to_cnt++;
    for (int i = 0; i < N; i++) if (grant[i] === 1'b1) g_cnt[i]++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic clr_cnt();
    plot_cnt = 0; fd_cnt = 0; ov_cnt = 0; to_cnt = 0;
    for (int i = 0; i < N; i++) g_cnt[i] = 0;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic wait_grant(int e);
    int t = 0;
    while (grant[e] !== 1'b1 && t < 40) begin @(negedge clk); t++; end
    chk($sformatf("grant%0d_arrives", e), grant[e], 1);
  endtask

  task automatic drive(int e, int k, bit last);
    pix_valid[e] = 1'b1;
    pix_x[e*XW +: XW]      = XW'(e * 100 + k);
    pix_y[e*YW +: YW]      = YW'(e * 10 + k);
    pix_colour[e*CW +: CW] = CW'((e + k) % 8);
    done[e] = last;
  endtask

  // Stream up to n pixels while granted; done on the n-th when use_done.
  task automatic serve(int e, int n, bit use_done, bit noise, int tick_at);
    wait_grant(e);
    for (int k = 0; k < n && grant[e] === 1'b1; k++) begin
      drive(e, k, use_done && (k == n - 1));
      if (noise) begin
        pix_valid[1:0] = (k % 2 != 0) ? 2'b01 : 2'b10;
        done[1:0]      = (k % 2 != 0) ? 2'b10 : 2'b01;
      end
      frame_tick = (k == tick_at);
      @(negedge clk);
    end
    pix_valid = '0; done = '0; frame_tick = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not end, %0d errors", errors);
    $fatal(1);
  end

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_plot", plot, 0);
    chk("rst_busy", busy, 0);
    chk("rst_x", x, 0);
    reset = 1'b0;
    @(negedge clk);

    // basic frame: all three engines, 4 pixels each
    clr_cnt();
    req = 3'b111; tick(); req = '0;
    serve(PLAYER, 4, 1, 0, -1);
    serve(ALIENS, 4, 1, 0, -1);
    serve(BULLET, 4, 1, 0, -1);
    repeat (4) @(negedge clk);
    chk("basic_plots", plot_cnt, 12);
    chk("basic_g0", g_cnt[0], 4);
    chk("basic_g2", g_cnt[2], 4);
    chk("basic_frame_done", fd_cnt, 1);
    chk("basic_busy_end", busy, 0);

    // sparse request with noise on non-granted engines
    clr_cnt();
    req = 3'b100; tick();
    serve(BULLET, 4, 1, 1, -1);
    repeat (4) @(negedge clk);
    chk("sparse_plots", plot_cnt, 4);
    chk("sparse_g0", g_cnt[0], 0);
    chk("sparse_g1", g_cnt[1], 0);

    // watchdog: aliens never raise done
    clr_cnt();
    req = 3'b110; tick();
    serve(ALIENS, 20, 0, 0, -1);
    serve(BULLET, 3, 1, 0, -1);
    repeat (4) @(negedge clk);
    chk("wd_g1_cycles", g_cnt[1], MB);
    chk("wd_timeouts", to_cnt, 1);
    chk("wd_plots", plot_cnt, MB + 3);
    chk("wd_frame_done", fd_cnt, 1);

    // overrun during burst, late request for bullet
    clr_cnt();
    req = 3'b011; tick(); req = 3'b111;
    serve(PLAYER, 4, 1, 0, 1);
    serve(ALIENS, 4, 1, 0, -1);
    repeat (6) @(negedge clk);
    chk("ovr_count", ov_cnt, 1);
    chk("ovr_late_g2", g_cnt[2], 0);
    chk("ovr_frame_done", fd_cnt, 1);
    req = 3'b100; tick(); req = '0;
    serve(BULLET, 2, 1, 0, -1);
    repeat (4) @(negedge clk);
    chk("late_g2", g_cnt[2], 2);
    chk("late_frame_done", fd_cnt, 2);

    // reset on the 3rd pixel of engine 0
    clr_cnt();
    req = 3'b001; tick();
    wait_grant(PLAYER);
    drive(PLAYER, 0, 0); @(negedge clk);
    drive(PLAYER, 1, 0); @(negedge clk);
    drive(PLAYER, 2, 0); reset = 1'b1; @(negedge clk);
    reset = 1'b0; pix_valid = '0;
    chk("rstmid_grant", grant, 0);
    chk("rstmid_plot", plot, 0);
    chk("rstmid_busy", busy, 0);
    @(negedge clk);
    clr_cnt();
    req = 3'b111; tick(); req = '0;
    serve(PLAYER, 2, 1, 0, -1);
    serve(ALIENS, 2, 1, 0, -1);
    serve(BULLET, 2, 1, 0, -1);
    repeat (4) @(negedge clk);
    chk("rstmid_clean_plots", plot_cnt, 6);
    chk("rstmid_clean_fd", fd_cnt, 1);

    // done together with a valid pixel at the frame corner
    clr_cnt();
    req = 3'b001; tick(); req = '0;
    wait_grant(PLAYER);
    pix_valid[0] = 1'b1; pix_x[0 +: XW] = 9'd319; pix_y[0 +: YW] = 8'd239;
    pix_colour[0 +: CW] = 3'b111; done[0] = 1'b1;
    @(negedge clk);
    done = '0;
    chk("dv_plot", plot, 1);
    chk("dv_x", x, 319);
    chk("dv_y", y, 239);
    chk("dv_colour", colour, 7);
    chk("dv_grant", grant, 0);
    repeat (3) @(negedge clk);
    pix_valid = '0;
    repeat (3) @(negedge clk);
    chk("dv_plots", plot_cnt, 1);
    chk("dv_frame_done", fd_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
